// File: rtl/fe_to_affine.sv
// Projective-to-affine conversion for curve25519: out = X * Z^(p-2) mod p, p = 2^255 - 19,
// built from one Fermat exponentiator, one field multiplier and a final canonicalising subtract.
module fe_to_affine #(
    parameter logic FREEZE = 1'b1
) (
    input  logic         clock,
    input  logic         reset_n,
    input  logic         start,
    input  logic [254:0] x_in,
    input  logic [254:0] z_in,
    output logic         busy,
    output logic         done,
    output logic [254:0] out
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXP  = 2'd1;
    localparam logic [1:0] MUL  = 2'd2;
    localparam logic [1:0] FRZ  = 2'd3;

    localparam logic [254:0] P_MOD     = ~255'd18;
    localparam logic [254:0] EXP_CONST = ~255'd20;

    // Input is below 2^255 < 2p, so a single conditional subtract is enough.
    function automatic logic [254:0] freeze_val(input logic [254:0] m);
        if (m >= P_MOD) begin
            return m - P_MOD;
        end else begin
            return m;
        end
    endfunction

    logic [1:0]   state_r;
    logic [254:0] x_r;
    logic [254:0] z_r;
    logic [254:0] inv_r;
    logic         exp_start_r;
    logic         mul_start_r;
    logic         busy_r;
    logic         done_r;
    logic [254:0] out_r;

    logic         exp_done_s;
    logic [254:0] exp_out_s;
    logic         mul_done_s;
    logic [254:0] mul_out_s;
    logic [254:0] final_s;

    feexp u_exp (
        .clock (clock),
        .start (exp_start_r),
        .x     (z_r),
        .e     (EXP_CONST),
        .done  (exp_done_s),
        .out   (exp_out_s)
    );

    femul u_mul (
        .clock (clock),
        .start (mul_start_r),
        .a     (x_r),
        .b     (inv_r),
        .done  (mul_done_s),
        .out   (mul_out_s)
    );

    // Canonicalise the product unless the debug pass-through is selected.
    always_comb begin
        final_s = mul_out_s;
        if (FREEZE) begin
            final_s = freeze_val(mul_out_s);
        end else begin
            final_s = mul_out_s;
        end
    end

    // Control FSM; the frozen result is registered on the multiplier done so that
    // out and done are both valid in the FRZ cycle.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= IDLE;
            x_r         <= 255'd0;
            z_r         <= 255'd0;
            inv_r       <= 255'd0;
            exp_start_r <= 1'b0;
            mul_start_r <= 1'b0;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            out_r       <= 255'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        x_r         <= x_in;
                        z_r         <= z_in;
                        exp_start_r <= 1'b1;
                        busy_r      <= 1'b1;
                        state_r     <= EXP;
                    end else begin
                        exp_start_r <= 1'b0;
                    end
                end
                EXP: begin
                    exp_start_r <= 1'b0;
                    if (exp_done_s) begin
                        inv_r       <= exp_out_s;
                        mul_start_r <= 1'b1;
                        state_r     <= MUL;
                    end else begin
                        mul_start_r <= 1'b0;
                    end
                end
                MUL: begin
                    mul_start_r <= 1'b0;
                    if (mul_done_s) begin
                        out_r   <= final_s;
                        done_r  <= 1'b1;
                        busy_r  <= 1'b0;
                        state_r <= FRZ;
                    end else begin
                        done_r <= 1'b0;
                    end
                end
                FRZ: begin
                    done_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    exp_start_r <= 1'b0;
                    mul_start_r <= 1'b0;
                    busy_r      <= 1'b0;
                    done_r      <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign out  = out_r;

endmodule

// Right-to-left square-and-multiply: one exponent bit per cycle, done 256 cycles after start.
// A start always restarts the engine, cancelling any operation in flight.
module feexp (
    input  logic         clock,
    input  logic         start,
    input  logic [254:0] x,
    input  logic [254:0] e,
    output logic         done,
    output logic [254:0] out
);

    logic [254:0] base_r;
    logic [254:0] acc_r;
    logic [254:0] exp_r;
    logic [7:0]   cnt_r;
    logic         run_r;
    logic [254:0] acc_mul_s;
    logic [254:0] base_sq_s;
    logic [254:0] acc_next_s;

    fe_mulmod u_acc (.a(acc_r),  .b(base_r), .y(acc_mul_s));
    fe_mulmod u_sq  (.a(base_r), .b(base_r), .y(base_sq_s));

    // Multiply the accumulator in only where the current exponent bit is set.
    always_comb begin
        acc_next_s = acc_r;
        if (exp_r[0]) begin
            acc_next_s = acc_mul_s;
        end else begin
            acc_next_s = acc_r;
        end
    end

    // Iteration state; deliberately reset-free, the parent ignores stray done pulses.
    always_ff @(posedge clock) begin
        if (start) begin
            base_r <= x;
            acc_r  <= 255'd1;
            exp_r  <= e;
            cnt_r  <= 8'd254;
            run_r  <= 1'b1;
            done   <= 1'b0;
        end else if (run_r) begin
            acc_r  <= acc_next_s;
            base_r <= base_sq_s;
            exp_r  <= {1'b0, exp_r[254:1]};
            if (cnt_r == 8'd0) begin
                run_r <= 1'b0;
                done  <= 1'b1;
                out   <= acc_next_s;
            end else begin
                cnt_r <= cnt_r - 8'd1;
                done  <= 1'b0;
            end
        end else begin
            done <= 1'b0;
        end
    end

endmodule

// Field multiplier with a registered result one cycle after start; output is < 2^255
// but may still be >= p.
module femul (
    input  logic         clock,
    input  logic         start,
    input  logic [254:0] a,
    input  logic [254:0] b,
    output logic         done,
    output logic [254:0] out
);

    logic [254:0] prod_s;

    fe_mulmod u_core (.a(a), .b(b), .y(prod_s));

    // Capture the product on start and flag it the following cycle.
    always_ff @(posedge clock) begin
        done <= start;
        if (start) begin
            out <= prod_s;
        end
    end

endmodule

// Combinational a*b reduced below 2^255 by folding with 2^255 == 19 (mod p).
module fe_mulmod (
    input  logic [254:0] a,
    input  logic [254:0] b,
    output logic [254:0] y
);

    function automatic logic [254:0] mul_mod(input logic [254:0] u, input logic [254:0] v);
        logic [509:0] prod;
        logic [260:0] t1;
        logic [255:0] t2;
        prod = {255'd0, u} * {255'd0, v};
        t1   = {6'd0, prod[254:0]} + ({6'd0, prod[509:255]} * 261'd19);
        t2   = {1'b0, t1[254:0]} + ({250'd0, t1[260:255]} * 256'd19);
        // When t2 overflows 2^255 its low part is tiny, so this last fold cannot overflow.
        return t2[254:0] + (t2[255] ? 255'd19 : 255'd0);
    endfunction

    // Pure function wrapper.
    always_comb begin
        y = mul_mod(a, b);
    end

endmodule

// File: tb/tb_fe_to_affine.sv
// Self-checking bench for fe_to_affine: directed vector table, multi-cycle corner sequences
// and random operands checked against the defining property out*z == x (mod p).
module tb_fe_to_affine;

    localparam int LAT     = 260;
    localparam int LAT_MAX = 600;

    logic         clock   = 1'b0;
    logic         reset_n = 1'b0;
    logic         start   = 1'b0;
    logic [254:0] x_in    = 255'd0;
    logic [254:0] z_in    = 255'd0;
    logic         busy;
    logic         done;
    logic [254:0] out;

    int checks = 0;
    int errors = 0;

    logic [254:0] p_mod;

    typedef struct {
        string        name;
        logic [254:0] x;
        logic [254:0] z;
        logic [254:0] want;
    } vec_t;

    vec_t vecs [8];

    always #5 clock = ~clock;

    fe_to_affine dut (
        .clock   (clock),
        .reset_n (reset_n),
        .start   (start),
        .x_in    (x_in),
        .z_in    (z_in),
        .busy    (busy),
        .done    (done),
        .out     (out)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic set_vec(input int idx, input string name, input logic [254:0] x,
                           input logic [254:0] z, input logic [254:0] want);
        vecs[idx].name = name;
        vecs[idx].x    = x;
        vecs[idx].z    = z;
        vecs[idx].want = want;
    endtask

    function automatic logic [254:0] rnd255();
        logic [255:0] t;
        for (int i = 0; i < 8; i++) t[32*i +: 32] = $urandom;
        return t[254:0];
    endfunction

    // One full operation: pulse start, wait (bounded) for done, report latency,
    // busy misbehaviour and whether done stayed high a second cycle.
    task automatic run_op(input logic [254:0] x, input logic [254:0] z,
                          output logic [254:0] got, output int lat,
                          output int busy_bad, output int extra);
        @(negedge clock);
        x_in  = x;
        z_in  = z;
        start = 1'b1;
        @(negedge clock);
        start    = 1'b0;
        lat      = -1;
        got      = 255'd0;
        busy_bad = 0;
        extra    = 0;
        for (int k = 1; k <= LAT_MAX; k++) begin
            if (done) begin
                lat = k;
                got = out;
                if (busy) busy_bad++;
                break;
            end
            if (!busy) busy_bad++;
            @(negedge clock);
        end
        @(negedge clock);
        if (done) extra = 1;
    endtask

    initial begin
        logic [254:0] got, got1, got2, xr, zr, half;
        logic [255:0] tmp;
        logic [511:0] pw, ow, xw, zw;
        int lat, lat1, lat2, busy_bad, extra, spurious;

        p_mod = ~255'd18;
        tmp   = {1'b0, p_mod} + 256'd1;
        half  = tmp[255:1];

        set_vec(0, "x5_z1",     255'd5,     255'd1,         255'd5);
        set_vec(1, "x1_z2",     255'd1,     255'd2,         half);
        set_vec(2, "x3_z3",     255'd3,     255'd3,         255'd1);
        set_vec(3, "z0",        255'd12345, 255'd0,         255'd0);
        set_vec(4, "z_eq_p",    255'd7,     p_mod,          255'd0);
        set_vec(5, "x_eq_p",    p_mod,      255'd1,         255'd0);
        set_vec(6, "x_max",     ~255'd0,    255'd1,         255'd18);
        set_vec(7, "z_p_plus1", 255'd6,     p_mod + 255'd1, 255'd6);

        // Reset values.
        repeat (3) @(negedge clock);
        check("rst_done", {255'd0, done}, 256'd0);
        check("rst_busy", {255'd0, busy}, 256'd0);
        check("rst_out",  {1'b0, out},    256'd0);
        reset_n = 1'b1;
        @(negedge clock);
        check("idle_busy", {255'd0, busy}, 256'd0);

        // Directed table.
        for (int i = 0; i < 8; i++) begin
            run_op(vecs[i].x, vecs[i].z, got, lat, busy_bad, extra);
            check({vecs[i].name, "_out"},   {1'b0, got},      {1'b0, vecs[i].want});
            check({vecs[i].name, "_lat"},   256'(lat),        256'(LAT));
            check({vecs[i].name, "_busy"},  256'(busy_bad),   256'd0);
            check({vecs[i].name, "_pulse"}, 256'(extra),      256'd0);
        end

        // Random operands against the field-inverse property.
        pw = {257'd0, p_mod};
        for (int i = 0; i < 200; i++) begin
            xr = rnd255();
            zr = rnd255();
            if (i % 25 == 0) zr = 255'd0;
            if (i % 25 == 1) zr = p_mod;
            if (i % 25 == 2) xr = ~255'd0;
            if (i % 25 == 3) zr = 255'($urandom_range(1, 1000));
            run_op(xr, zr, got, lat, busy_bad, extra);
            ow = {257'd0, got};
            xw = {257'd0, xr};
            zw = {257'd0, zr};
            check("rand_lat",   256'(lat), 256'(LAT));
            check("rand_canon", {255'd0, (got < p_mod)}, 256'd1);
            if (zw % pw == 512'd0) begin
                check("rand_zero", {1'b0, got}, 256'd0);
            end else begin
                tmp = 256'((ow * zw) % pw);
                check("rand_residue", tmp, 256'(xw % pw));
            end
        end

        // start held high through EXP/MUL and the done cycle, then reused the cycle after done.
        @(negedge clock);
        x_in  = 255'd11;
        z_in  = 255'd1;
        start = 1'b1;
        lat1  = -1;
        got1  = 255'd0;
        for (int k = 1; k <= LAT_MAX; k++) begin
            @(negedge clock);
            x_in = 255'd99;
            if (done) begin
                lat1 = k;
                got1 = out;
                break;
            end
        end
        @(negedge clock);
        check("hold_pulse", {255'd0, done}, 256'd0);
        x_in = 255'd42;
        @(negedge clock);
        start = 1'b0;
        lat2  = -1;
        got2  = 255'd0;
        for (int k = 1; k <= LAT_MAX; k++) begin
            if (done) begin
                lat2 = k;
                got2 = out;
                break;
            end
            @(negedge clock);
        end
        check("hold_out",  {1'b0, got1}, 256'd11);
        check("hold_lat",  256'(lat1),   256'(LAT));
        check("after_out", {1'b0, got2}, 256'd42);
        check("after_lat", 256'(lat2),   256'(LAT));

        // Reset in the middle of EXP.
        @(negedge clock);
        x_in  = 255'd21;
        z_in  = 255'd5;
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        repeat (100) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midrst_done", {255'd0, done}, 256'd0);
        check("midrst_busy", {255'd0, busy}, 256'd0);
        check("midrst_out",  {1'b0, out},    256'd0);
        @(negedge clock);
        reset_n  = 1'b1;
        spurious = 0;
        repeat (400) begin
            @(negedge clock);
            if (done) spurious++;
        end
        check("midrst_spurious", 256'(spurious), 256'd0);
        run_op(255'd9, 255'd1, got, lat, busy_bad, extra);
        check("midrst_next_out", {1'b0, got}, 256'd9);
        check("midrst_next_lat", 256'(lat),   256'(LAT));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/fe_to_affine.md
Name: fe_to_affine

Overview:
- Final stage of the scalar-multiplication datapath. It consumes a projective coordinate pair (X, Z) from the ladder and produces the affine coordinate X·Z⁻¹ mod p, where p = 2^255 − 19.
- It instantiates one feexp, which computes Z^(p−2) = Z⁻¹ by Fermat inversion.
- It instantiates one femul for the final product.
- A final conditional-subtract stage emits a canonical value in [0, p).

Parameters:
- FREEZE, default 1. When 1, the conditional subtract of p is applied to the output. When 0, the femul result passes through unchanged (debug only).

Ports:
- clock  input  1  — system clock; all state changes on the rising edge.
- reset_n  input  1  — asynchronous, active-low reset.
- start  input  1  — single-cycle request. Sampled only in IDLE.
- x_in  input  255  — projective X. Any 255-bit value is allowed; non-canonical values are accepted.
- z_in  input  255  — projective Z. Any 255-bit value is allowed.
- busy  output  1  — high from the cycle after an accepted start until the done cycle. busy is low in the done cycle.
- done  output  1  — single-cycle pulse; out is valid in the same cycle.
- out  output  255  — canonical affine result. It holds its value until the next done pulse.

Behaviour:
- Reset values: done=0, busy=0, out=0, state=IDLE, exp_start=0, mul_start=0, x_reg=0.
- Reset is asserted asynchronously and released synchronously to clock.
- States:
  - IDLE: when start=1, latch x_reg<=x_in and z_reg<=z_in, pulse exp_start for one cycle, set busy=1, and go to EXP. start in any other state is ignored; no queuing.
  - EXP: feexp is driven with x=z_reg and e=EXP_CONST (255'h7FFF…FFEB = p−2). Wait for the feexp done pulse, then capture inv<=feexp.out, pulse mul_start for one cycle with a=x_reg and b=inv, and go to MUL.
  - MUL: wait for the femul done pulse, capture m<=femul.out, and go to FRZ.
  - FRZ (one cycle):
    - If FREEZE is 1 and m ≥ p, then out<=m−p; otherwise out<=m.
    - Comparison and subtraction are 256-bit unsigned. The result is always < p, because m < 2^255 < 2p.
    - Assert done=1, set busy=0, and return to IDLE.
- Latency: start to done = 1 + T_exp + 1 + T_mul + 1 cycles, where T_exp and T_mul are the submodule start-to-done latencies.
- Throughput: one result per latency period. A start in the done cycle is ignored. A start in the cycle after done is accepted.
- Submodule operand buses are driven from registers only (z_reg, x_reg, inv) and remain stable for the whole submodule operation.
- Submodule done pulses arriving in any state other than the one waiting for them are ignored. This covers the in-flight pulses that remain after a mid-operation reset, since feexp and femul have no reset.
- Reset mid-operation:
  - Outputs and state return to reset values immediately.
  - The next accepted start re-pulses the submodule start, which restarts feexp and femul cleanly.
  - No done pulse is produced for the aborted operation.
- Z ≡ 0 (mod p) gives inv=0, so out=0. This is not an error; no flag is raised.
- Inputs ≥ p are reduced implicitly by femul. The freeze stage guarantees a canonical out.

Test Plan:
- x_in=5, z_in=1, start pulse → exactly one done pulse after the documented latency; out=5. busy is high throughout and drops in the done cycle.
- x_in=1, z_in=2 → out=(p+1)/2=255'h3FFF…FFF7. Also x_in=3, z_in=3 → out=1.
- z_in=0, x_in=12345 → out=0 and done is asserted normally. Also z_in=p (255'h7FFF…FFED), x_in=7 → out=0.
- Freeze path: x_in=p, z_in=1 → out=0. Also x_in=2^255−1, z_in=1 → out=18. Check against a reference model for 200 random (x, z) pairs, with out<p always.
- start re-asserted every cycle during EXP and MUL → ignored; only one done pulse, and out matches the first operands. A start in the cycle after done is accepted.
- reset_n pulled low midway through EXP → done=0, busy=0, out=0 immediately, and no spurious done afterwards. A new start with x_in=9, z_in=1 then yields out=9 with normal latency.
